// File: rtl/single_mem_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package single_mem_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } arb_state_e;

endpackage

// File: rtl/single_mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory-side signals of the arbiter.
interface single_mem_arbiter_if #(
    parameter int ADDR_W = single_mem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = single_mem_arb_pkg::DEF_DATA_W
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_wen;
    logic              d_b;
    logic              d_h;
    logic              d_u;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_wen;
    logic              mem_b;
    logic              mem_h;
    logic              mem_u;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  if_req, if_addr,
        output if_valid, if_rdata,
        input  d_req, d_wen, d_b, d_h, d_u, d_addr, d_wdata,
        output d_valid, d_rdata,
        output mem_wen, mem_b, mem_h, mem_u, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output if_req, if_addr,
        input  if_valid, if_rdata,
        output d_req, d_wen, d_b, d_h, d_u, d_addr, d_wdata,
        input  d_valid, d_rdata,
        input  mem_wen, mem_b, mem_h, mem_u, mem_addr, mem_din,
        output mem_dout
    );

endinterface

// File: rtl/single_mem_arbiter_sat_counter.sv
// Saturating up-counter with async active-low clear; only built with SINGLE_MEM_ARB_STALL_CNT_EN.
`ifdef SINGLE_MEM_ARB_STALL_CNT_EN
module arb_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold at all-ones once reached
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/single_mem_arbiter.sv
// Fetch / load-store arbiter in front of the unified memory; data wins from IDLE, ports alternate under contention.
// SINGLE_MEM_ARB_STALL_CNT_EN enables the saturating wait-cycle counter on stall_cnt.
module single_mem_arbiter
    import single_mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    single_mem_arbiter_if.slave  bus,
    output logic                 stall,
    output logic [CNT_W-1:0]     stall_cnt
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              issue_d_s;
    logic              issue_i_s;
    logic              d_valid_s;
    logic              if_valid_s;
    logic              mem_wen_s;
    logic              mem_b_s;
    logic              mem_h_s;
    logic              mem_u_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_din_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant decision; the port completing this cycle is not eligible, which yields alternation
    always_comb begin
        issue_d_s = 1'b0;
        issue_i_s = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.d_req) begin
                        issue_d_s = 1'b1;
                    end else if (bus.if_req) begin
                        issue_i_s = 1'b1;
                    end else begin
                        issue_i_s = 1'b0;
                    end
                end
                BUSY_D: begin
                    if (bus.if_req) begin
                        issue_i_s = 1'b1;
                    end else begin
                        issue_i_s = 1'b0;
                    end
                end
                BUSY_I: begin
                    if (bus.d_req) begin
                        issue_d_s = 1'b1;
                    end else begin
                        issue_d_s = 1'b0;
                    end
                end
                default: begin
                    issue_d_s = 1'b0;
                    issue_i_s = 1'b0;
                end
            endcase
        end else begin
            issue_d_s = 1'b0;
            issue_i_s = 1'b0;
        end
        if (issue_d_s) begin
            state_d = BUSY_D;
        end else if (issue_i_s) begin
            state_d = BUSY_I;
        end else begin
            state_d = IDLE;
        end
    end

    // Memory-side mux; everything reads as zero when nothing is issued
    always_comb begin
        mem_wen_s  = 1'b0;
        mem_b_s    = 1'b0;
        mem_h_s    = 1'b0;
        mem_u_s    = 1'b0;
        mem_addr_s = {ADDR_W{1'b0}};
        mem_din_s  = {DATA_W{1'b0}};
        if (issue_d_s) begin
            mem_wen_s  = bus.d_wen;
            mem_b_s    = bus.d_b;
            mem_h_s    = bus.d_h;
            mem_u_s    = bus.d_u;
            mem_addr_s = bus.d_addr;
            mem_din_s  = bus.d_wdata;
        end else if (issue_i_s) begin
            mem_addr_s = bus.if_addr;
        end else begin
            mem_wen_s  = 1'b0;
        end
    end

    assign d_valid_s    = (state_q == BUSY_D);
    assign if_valid_s   = (state_q == BUSY_I);

    assign bus.mem_wen  = mem_wen_s;
    assign bus.mem_b    = mem_b_s;
    assign bus.mem_h    = mem_h_s;
    assign bus.mem_u    = mem_u_s;
    assign bus.mem_addr = mem_addr_s;
    assign bus.mem_din  = mem_din_s;

    assign bus.d_valid  = d_valid_s;
    assign bus.d_rdata  = bus.mem_dout;
    assign bus.if_valid = if_valid_s;
    assign bus.if_rdata = bus.mem_dout;

    assign stall = (bus.if_req & ~if_valid_s) | (bus.d_req & ~d_valid_s);

`ifdef SINGLE_MEM_ARB_STALL_CNT_EN
    logic wait_s;

    // A cycle counts as waiting when a requesting port is neither issued nor completing
    assign wait_s = (bus.d_req  & ~issue_d_s & ~d_valid_s) |
                    (bus.if_req & ~issue_i_s & ~if_valid_s);

    arb_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (wait_s),
        .cnt_o (stall_cnt)
    );
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/single_mem_arbiter.md
# single_mem_arbiter

Two-port arbiter that shares the single unified memory between the instruction-fetch path and the load/store path of the CPU. It sits directly upstream of `single_memory`, drives its `wen/b/h/u/addr/din` inputs, and returns its already-extended `dout` to whichever port issued the access. Each port gets a valid pulse when its access completes, and a stall output holds the pipeline while either port waits.

## Interface
- `ADDR_W`, 10: memory address width (matches `single_memory`).
- `DATA_W`, 32: data width.
- `CNT_W`, 16: width of the stall counter.

- `clk`  in  1  single clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  instruction read request; held until `if_valid`.
- `if_addr`  in  ADDR_W  instruction address.
- `if_valid`  out  1  one-cycle pulse: `if_rdata` valid.
- `if_rdata`  out  DATA_W  fetched word.
- `d_req`  in  1  data request; held until `d_valid`.
- `d_wen`, `d_b`, `d_h`, `d_u`  in  1 each  store enable, byte, half and unsigned qualifiers.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_valid`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  DATA_W  load result (don't-care for stores).
- `mem_wen`, `mem_b`, `mem_h`, `mem_u`  out  1 each  to memory.
- `mem_addr`  out  ADDR_W  to memory.
- `mem_din`  out  DATA_W  to memory.
- `mem_dout`  in  DATA_W  from memory; valid one cycle after issue.
- `stall`  out  1  a request is pending and has not yet completed.
- `stall_cnt`  out  CNT_W  wait-cycle counter (see Configuration).

## Operation
- States: IDLE, BUSY_D, BUSY_I. Reset state is IDLE.
- IDLE:
  - If `d_req`: issue the data access and go to BUSY_D.
  - Else if `if_req`: issue the instruction access and go to BUSY_I.
  - Else stay in IDLE.
- Issue means `mem_*` is driven combinationally from the selected port in that cycle. Instruction issue drives `mem_wen=0`, `mem_b=0`, `mem_h=0`, `mem_u=0`. When nothing is issued, `mem_wen=0`.
- BUSY_D:
  - Assert `d_valid`, with `d_rdata=mem_dout`.
  - `d_req` is ignored this cycle; it is the request just completing.
  - If `if_req`: issue the instruction access and go to BUSY_I. Else go to IDLE.
- BUSY_I:
  - Assert `if_valid`, with `if_rdata=mem_dout`.
  - `if_req` is ignored this cycle.
  - If `d_req`: issue the data access and go to BUSY_D. Else go to IDLE.
- Result: data has priority from IDLE, and the ports alternate under contention. A port never gets two consecutive issues while the other port waits.
- Requesters drop `req` in the cycle after `valid`, or re-present a new request then. Changing request fields while `req` is high and not yet issued is illegal.
- `stall = (if_req & ~if_valid) | (d_req & ~d_valid)`.
- `mem_wen` is high only in the issue cycle, so each store writes exactly once.

## Timing
- Latency from issue to valid is 1 cycle. A request arriving in IDLE with no contention completes the next cycle.
- Throughput is 1 access/cycle while both ports alternate, and 1 access per 2 cycles for a single port.
- Reset while `rst` is low:
  - state=IDLE; `if_valid`, `d_valid` = 0.
  - `mem_wen`, `mem_b`, `mem_h`, `mem_u` = 0; `mem_addr`=0; `mem_din`=0.
  - `stall_cnt`=0; `stall` is still computed from the request inputs.
- Reset mid-access: the in-flight access is dropped and no valid pulse is produced. The requester keeps `req` high, and the access is reissued from IDLE after reset release. A store already clocked into memory is not undone.

## Configuration
- `SINGLE_MEM_ARB_STALL_CNT_EN` defined:
  - `stall_cnt` increments by 1 in every cycle in which at least one port has `req` high, is not being issued, and is not in its completion cycle.
  - The counter saturates at all-ones and clears only on reset.
- Not defined: `stall_cnt` is tied to 0 and no counter flops exist.

## Structure
- Package `single_mem_arb_pkg` holds:
  - the state enum (IDLE, BUSY_D, BUSY_I);
  - the `ADDR_W`, `DATA_W` and `CNT_W` defaults.
- One sub-module, `arb_sat_counter`: a saturating up-counter with async active-low clear, instantiated only under the macro.

## Test plan
- Reset: hold `rst=0` with both requests high -> `mem_wen=0`, `if_valid=d_valid=0`, `stall_cnt=0`; after release, data is issued first.
- Lone fetch: `if_req=1`, `if_addr=0x010` at cycle 0 -> `mem_addr=0x010`, `mem_wen=0` at cycle 0; `if_valid=1` at cycle 1 with `if_rdata` equal to the word at 0x010.
- Contention: both requests at cycle 0 -> data issued at cycle 0, `d_valid` and instruction issue at cycle 1, `if_valid` at cycle 2. With the macro, `stall_cnt=1`.
- Store/load byte:
  - Store `d_wen=1`, `d_b=1`, `d_addr=0x003`, `d_wdata=0xAB` -> `mem_wen` high for exactly 1 cycle.
  - Then `d_u=0` load -> `d_rdata=0xFFFFFFAB`.
  - Then `d_u=1` load -> `d_rdata=0x000000AB`.
- Reset mid-access: pull `rst` low during the BUSY_D cycle -> no `d_valid`; after release, the held `d_req` is reissued and completes 1 cycle later.
- Macro off, contention as in scenario 3 -> `stall_cnt` stays 0 throughout.
